array3d_stream_writer: RTL

- Fills a 3-D unpacked array [D0][D1][D2] of W-bit words from a valid/ready input stream.
- Element order is row-major nested-index (i outer, j middle, k inner), the same order as a foreach over array[i, j, k].
- Acts as the producer side for the array-reduction blocks.
- Contents are read back through a registered random-access read port.

---
 rtl/array3d_stream_writer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/array3d_stream_writer.sv
// array3d_stream_writer
//   Fills a D0 x D1 x D2 array of W-bit words from a valid/ready stream in
//   row-major order (i outer, j middle, k inner). Contents are read back
//   through a registered random-access port that is live in every state.
//
//   Optional build macro: ARRAY3D_WRITER_ACCUMULATE_EN
//     defined   : transfers add into the element (wrap-around), start keeps
//                 the array, and a 'clear' input zeroes the array in IDLE.
//     undefined : transfers overwrite the element; no 'clear' port.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   clear                      (accumulate build only) zero array in IDLE
//   start                      begin a fill pass (sampled in IDLE only)
//   in_valid/in_ready/in_data  input stream
//   busy                       high while filling
//   done                       one-cycle pulse after the last element
//   fill_count                 elements written in current/last pass
//   cur_i/cur_j/cur_k          target index of the next accepted word
//   rd_i/rd_j/rd_k, rd_data    read address, registered read data
module array3d_stream_writer #(
   parameter int D0 = 2,
   parameter int D1 = 3,
   parameter int D2 = 4,
   parameter int W  = 32,
   localparam int IW0 = (D0 > 1) ? $clog2(D0) : 1,
   localparam int IW1 = (D1 > 1) ? $clog2(D1) : 1,
   localparam int IW2 = (D2 > 1) ? $clog2(D2) : 1,
   localparam int N   = D0 * D1 * D2,
   localparam int CW  = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
`ifdef ARRAY3D_WRITER_ACCUMULATE_EN
   input  logic           clear,
`endif
   input  logic           start,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           busy,
   output logic           done,
   output logic [CW-1:0]  fill_count,
   output logic [IW0-1:0] cur_i,
   output logic [IW1-1:0] cur_j,
   output logic [IW2-1:0] cur_k,
   input  logic [IW0-1:0] rd_i,
   input  logic [IW1-1:0] rd_j,
   input  logic [IW2-1:0] rd_k,
   output logic [W-1:0]   rd_data
);

   localparam logic [IW0-1:0] I_LAST = IW0'(D0 - 1);
   localparam logic [IW1-1:0] J_LAST = IW1'(D1 - 1);
   localparam logic [IW2-1:0] K_LAST = IW2'(D2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   mem [D0][D1][D2];
   logic           xfer;
   logic           last_k, last_j, last_i, last_elem;
   logic           rd_ok;
   logic           wipe;

   assign xfer      = in_valid & in_ready;
   assign last_k    = (cur_k == K_LAST);
   assign last_j    = (cur_j == J_LAST);
   assign last_i    = (cur_i == I_LAST);
   assign last_elem = last_i & last_j & last_k;

   // Indices narrower than a power of two can still address past the end.
   assign rd_ok = (32'(rd_i) < 32'(D0)) && (32'(rd_j) < 32'(D1)) &&
                  (32'(rd_k) < 32'(D2));

`ifdef ARRAY3D_WRITER_ACCUMULATE_EN
   assign wipe = clear & (state == S_IDLE);
`else
   assign wipe = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FILL;
         S_FILL:  if (xfer && last_elem) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_FILL: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- write index and element count ----------------
   // The final transfer wraps every index back to 0 by the same carry chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_i      <= '0;
         cur_j      <= '0;
         cur_k      <= '0;
         fill_count <= '0;
      end else if (state == S_IDLE && start) begin
         cur_i      <= '0;
         cur_j      <= '0;
         cur_k      <= '0;
         fill_count <= '0;
      end else if (xfer) begin
         fill_count <= fill_count + CW'(1);
         cur_k      <= last_k ? '0 : cur_k + IW2'(1);
         if (last_k) begin
            cur_j <= last_j ? '0 : cur_j + IW1'(1);
            if (last_j) cur_i <= last_i ? '0 : cur_i + IW0'(1);
         end
      end
   end

   // ---------------- array storage ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < D0; a++)
            for (int b = 0; b < D1; b++)
               for (int c = 0; c < D2; c++)
                  mem[a][b][c] <= '0;
      end else if (wipe) begin
         for (int a = 0; a < D0; a++)
            for (int b = 0; b < D1; b++)
               for (int c = 0; c < D2; c++)
                  mem[a][b][c] <= '0;
      end else if (xfer) begin
`ifdef ARRAY3D_WRITER_ACCUMULATE_EN
         mem[cur_i][cur_j][cur_k] <= mem[cur_i][cur_j][cur_k] + in_data;
`else
         mem[cur_i][cur_j][cur_k] <= in_data;
`endif
      end
   end

   // ---------------- registered read port ----------------
   // Reads the pre-edge contents, so a same-edge write is seen one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_ok) rd_data <= mem[rd_i][rd_j][rd_k];
      else            rd_data <= '0;
   end

endmodule
